// File: rtl/seven_seg_scan_controller_if.sv
// Producer-side load bus for the seven-segment scan controller.
// The producer (master) drives value/dp/load/blank_lz; the controller (slave) reports pending/frame_tick.
interface seven_seg_scan_controller_if;
    logic [15:0] value_in;
    logic [3:0]  dp_in;
    logic        load;
    logic        blank_lz;
    logic        pending;
    logic        frame_tick;

    modport master (
        output value_in, dp_in, load, blank_lz,
        input  pending, frame_tick
    );

    modport slave (
        input  value_in, dp_in, load, blank_lz,
        output pending, frame_tick
    );
endinterface

// File: rtl/seven_seg_scan_controller.sv
// Four-digit multiplexed seven-segment scanner with shadow-register loading,
// frame-boundary commit, dead-time anti-ghosting and leading-zero blanking.
module seven_seg_scan_controller #(
    parameter int REFRESH_DIV = 100000,
    parameter int DEAD_CYCLES = 1000
) (
    input  logic                         clock_100Mhz,
    input  logic                         reset,
    seven_seg_scan_controller_if.slave   bus,
    output logic [3:0]                   Anode_Activate,
    output logic [6:0]                   LED_out,
    output logic                         dp_out
);

    localparam int SLOT_W = $clog2(REFRESH_DIV);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(REFRESH_DIV - 1);
    localparam logic [SLOT_W-1:0] DEAD_END  = SLOT_W'(DEAD_CYCLES);

    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [1:0]        digit_q, digit_d;
    logic [15:0]       shadow_q, shadow_d;
    logic [3:0]        shadow_dp_q, shadow_dp_d;
    logic [15:0]       disp_q, disp_d;
    logic [3:0]        disp_dp_q, disp_dp_d;
    logic              pending_q, pending_d;
    logic [3:0]        anode_q, anode_d;
    logic [6:0]        led_q, led_d;
    logic              dpo_q, dpo_d;
    logic              slot_wrap;
    logic              commit;
    logic [3:0]        nib;
    logic              lz_blank;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = 7'b1111110;
        endcase
        return s;
    endfunction

    assign slot_wrap = (slot_q == SLOT_LAST);
    assign commit    = slot_wrap && (digit_q == 2'd3);

    // Scan position and load/commit handshake
    always_comb begin
        slot_d      = slot_q + SLOT_W'(1);
        digit_d     = digit_q;
        if (slot_wrap) begin
            slot_d  = '0;
            digit_d = digit_q + 2'd1;
        end

        shadow_d    = shadow_q;
        shadow_dp_d = shadow_dp_q;
        pending_d   = pending_q;
        disp_d      = disp_q;
        disp_dp_d   = disp_dp_q;

        // Commit sees the pre-edge shadow, so a load on the commit cycle lands next frame.
        if (commit) begin
            pending_d = 1'b0;
            if (pending_q) begin
                disp_d    = shadow_q;
                disp_dp_d = shadow_dp_q;
            end
        end
        if (bus.load) begin
            shadow_d    = bus.value_in;
            shadow_dp_d = bus.dp_in;
            pending_d   = 1'b1;
        end
    end

    // Digit select, decode and blanking feeding the output registers
    always_comb begin
        case (digit_q)
            2'd0:    begin nib = disp_q[3:0];   lz_blank = 1'b0;                 end
            2'd1:    begin nib = disp_q[7:4];   lz_blank = (disp_q[15:4]  == '0); end
            2'd2:    begin nib = disp_q[11:8];  lz_blank = (disp_q[15:8]  == '0); end
            default: begin nib = disp_q[15:12]; lz_blank = (disp_q[15:12] == '0); end
        endcase

        anode_d = 4'b1111;
        led_d   = 7'b1111111;
        dpo_d   = 1'b1;
        if (!(slot_q < DEAD_END)) begin
            anode_d[digit_q] = 1'b0;
            led_d            = (bus.blank_lz && lz_blank) ? 7'b1111111 : bcd_to_seg(nib);
            dpo_d            = ~disp_dp_q[digit_q];
        end
    end

    always_ff @(posedge clock_100Mhz or posedge reset) begin
        if (reset) begin
            slot_q      <= '0;
            digit_q     <= '0;
            shadow_q    <= '0;
            shadow_dp_q <= '0;
            disp_q      <= '0;
            disp_dp_q   <= '0;
            pending_q   <= 1'b0;
            anode_q     <= 4'b1111;
            led_q       <= 7'b1111111;
            dpo_q       <= 1'b1;
        end else begin
            slot_q      <= slot_d;
            digit_q     <= digit_d;
            shadow_q    <= shadow_d;
            shadow_dp_q <= shadow_dp_d;
            disp_q      <= disp_d;
            disp_dp_q   <= disp_dp_d;
            pending_q   <= pending_d;
            anode_q     <= anode_d;
            led_q       <= led_d;
            dpo_q       <= dpo_d;
        end
    end

    assign bus.pending     = pending_q;
    assign bus.frame_tick  = commit;
    assign Anode_Activate  = anode_q;
    assign LED_out         = led_q;
    assign dp_out          = dpo_q;

endmodule

// File: tb/tb_seven_seg_scan_controller.sv
// Randomised and directed bench for seven_seg_scan_controller against a
// cycle-indexed behavioural model of the scan/commit rules.
module tb_seven_seg_scan_controller;

    localparam int R     = 8;
    localparam int D     = 2;
    localparam int FRAME = 4 * R;

    logic       clk;
    logic       reset;
    logic [3:0] Anode_Activate;
    logic [6:0] LED_out;
    logic       dp_out;

    seven_seg_scan_controller_if bus ();

    seven_seg_scan_controller #(.REFRESH_DIV(R), .DEAD_CYCLES(D)) dut (
        .clock_100Mhz   (clk),
        .reset          (reset),
        .bus            (bus),
        .Anode_Activate (Anode_Activate),
        .LED_out        (LED_out),
        .dp_out         (dp_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: n = cycles since reset release; registers updated per edge.
    int          n;
    logic [15:0] m_shadow, m_disp;
    logic [3:0]  m_sdp, m_ddp;
    bit          m_pend;
    logic [3:0]  exp_anode;
    logic [6:0]  exp_led;
    logic        exp_dp, exp_pend, exp_tick;
    logic [6:0]  seg_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                                  7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

    function automatic logic [6:0] seg_of(input int v);
        return (v > 9) ? 7'b1111110 : seg_tab[v];
    endfunction

    function automatic logic [13:0] got_vec();
        return {Anode_Activate, LED_out, dp_out, bus.pending, bus.frame_tick};
    endfunction

    function automatic logic [13:0] exp_vec();
        return {exp_anode, exp_led, exp_dp, exp_pend, exp_tick};
    endfunction

    task automatic model_init();
        n = 0; m_shadow = '0; m_disp = '0; m_sdp = '0; m_ddp = '0; m_pend = 0;
        exp_anode = 4'b1111; exp_led = 7'b1111111; exp_dp = 1'b1; exp_pend = 1'b0; exp_tick = 1'b0;
    endtask

    // Advance one clock, predicting the outputs of the next cycle.
    task automatic step();
        int slot, dig, upper;
        slot = n % R;
        dig  = (n / R) % 4;
        if (slot < D) begin
            exp_anode = 4'b1111; exp_led = 7'b1111111; exp_dp = 1'b1;
        end else begin
            upper     = int'(m_disp) >> (4 * dig);
            exp_anode = ~(4'b0001 << dig);
            exp_led   = (bus.blank_lz && dig > 0 && upper == 0) ? 7'b1111111 : seg_of(upper % 16);
            exp_dp    = ~m_ddp[dig];
        end
        if ((n % FRAME) == FRAME - 1) begin
            if (m_pend) begin m_disp = m_shadow; m_ddp = m_sdp; end
            m_pend = 0;
        end
        if (bus.load) begin m_shadow = bus.value_in; m_sdp = bus.dp_in; m_pend = 1; end
        n++;
        exp_pend = m_pend;
        exp_tick = ((n % FRAME) == FRAME - 1);
        @(posedge clk); #1;
        bus.load = 1'b0;
        @(negedge clk);
    endtask

    task automatic apply_reset();
        bus.load = 1'b0;
        reset = 1'b1;
        #2;
        model_init();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    task automatic load_val(input logic [15:0] v, input logic [3:0] dp);
        bus.value_in = v; bus.dp_in = dp; bus.load = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        checks++;
        if ({Anode_Activate, LED_out, dp_out, bus.pending} !== {4'b1111, 7'b1111111, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs got=%h exp=%h", {Anode_Activate, LED_out, dp_out, bus.pending},
                     {4'b1111, 7'b1111111, 1'b1, 1'b0});
        end
        apply_reset();
        for (int c = 0; c <= 3; c++) begin
            checks++;
            if (got_vec() !== exp_vec()) begin
                errors++; $display("FAIL reset_scan c=%0d got=%h exp=%h", c, got_vec(), exp_vec());
            end
            if (c == 3) begin
                checks++;
                if (Anode_Activate !== 4'b1110) begin
                    errors++; $display("FAIL first_lit got=%b exp=1110", Anode_Activate);
                end
            end
            if (c < 3) step();
        end
    endtask

    task automatic test_load_commit();
        logic [3:0] an_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        logic [6:0] ld_tab [4] = '{7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111};
        bus.blank_lz = 1'b0;
        apply_reset();
        load_val(16'h1234, 4'b0101);
        for (int c = 0; c < 96; c++) begin
            checks++;
            if (got_vec() !== exp_vec()) begin
                errors++; $display("FAIL load_commit c=%0d got=%h exp=%h", c, got_vec(), exp_vec());
            end
            if (c >= 1 && c <= 31) begin
                checks++;
                if (bus.pending !== 1'b1) begin
                    errors++; $display("FAIL pending_hold c=%0d got=%b exp=1", c, bus.pending);
                end
            end
            if (c == 31 || c == 63) begin
                checks++;
                if (bus.frame_tick !== 1'b1) begin
                    errors++; $display("FAIL frame_tick c=%0d got=%b exp=1", c, bus.frame_tick);
                end
            end
            if (c >= 35 && c <= 59 && (c - 35) % 8 == 0) begin
                checks++;
                if ({Anode_Activate, LED_out} !== {an_tab[(c - 35) / 8], ld_tab[(c - 35) / 8]}) begin
                    errors++;
                    $display("FAIL digit_scan c=%0d got=%b_%b exp=%b_%b", c, Anode_Activate, LED_out,
                             an_tab[(c - 35) / 8], ld_tab[(c - 35) / 8]);
                end
            end
            step();
        end
    endtask

    task automatic test_blanking();
        logic [6:0] on_tab  [4] = '{7'b0001111, 7'b1111111, 7'b1111111, 7'b1111111};
        logic [6:0] off_tab [4] = '{7'b0001111, 7'b0000001, 7'b0000001, 7'b0000001};
        bus.blank_lz = 1'b1;
        apply_reset();
        load_val(16'h0007, 4'b0000);
        for (int c = 0; c < 96; c++) begin
            if (c == 64) bus.blank_lz = 1'b0;
            checks++;
            if (got_vec() !== exp_vec()) begin
                errors++; $display("FAIL blanking c=%0d got=%h exp=%h", c, got_vec(), exp_vec());
            end
            if (c >= 35 && c <= 59 && (c - 35) % 8 == 0) begin
                checks++;
                if (LED_out !== on_tab[(c - 35) / 8]) begin
                    errors++; $display("FAIL lz_on c=%0d got=%b exp=%b", c, LED_out, on_tab[(c - 35) / 8]);
                end
            end
            if (c >= 67 && c <= 91 && (c - 67) % 8 == 0) begin
                checks++;
                if (LED_out !== off_tab[(c - 67) / 8]) begin
                    errors++; $display("FAIL lz_off c=%0d got=%b exp=%b", c, LED_out, off_tab[(c - 67) / 8]);
                end
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        bus.blank_lz = 1'b0;
        apply_reset();
        load_val(16'h00A5, 4'b0000);
        for (int c = 0; c < 72; c++) begin
            checks++;
            if (got_vec() !== exp_vec()) begin
                errors++; $display("FAIL commit_load c=%0d got=%h exp=%h", c, got_vec(), exp_vec());
            end
            if (c == 32) begin
                checks++;
                if (bus.pending !== 1'b1) begin
                    errors++; $display("FAIL pending_after_commit_load got=%b exp=1", bus.pending);
                end
            end
            if (c == 35 || c == 43 || c == 67) begin
                checks++;
                if (LED_out !== (c == 35 ? 7'b0100100 : (c == 43 ? 7'b1111110 : 7'b1001111))) begin
                    errors++;
                    $display("FAIL invalid_or_next c=%0d got=%b exp=%b", c, LED_out,
                             (c == 35 ? 7'b0100100 : (c == 43 ? 7'b1111110 : 7'b1001111)));
                end
            end
            if (c == 31) load_val(16'h1111, 4'b0000);
            step();
        end
    endtask

    task automatic test_reset_mid();
        bus.blank_lz = 1'b0;
        apply_reset();
        load_val(16'h9999, 4'b1111);
        for (int c = 0; c <= 52; c++) begin
            checks++;
            if (got_vec() !== exp_vec()) begin
                errors++; $display("FAIL pre_reset c=%0d got=%h exp=%h", c, got_vec(), exp_vec());
            end
            if (c < 52) step();
        end
        checks++;
        if ({Anode_Activate, LED_out} !== {4'b1011, 7'b0000100}) begin
            errors++; $display("FAIL digit2_nine got=%b_%b exp=1011_0000100", Anode_Activate, LED_out);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({Anode_Activate, LED_out, dp_out, bus.pending, bus.frame_tick} !== 14'b1111_1111111_1_0_0) begin
            errors++;
            $display("FAIL mid_reset got=%b exp=%b", {Anode_Activate, LED_out, dp_out, bus.pending, bus.frame_tick},
                     14'b1111_1111111_1_0_0);
        end
        apply_reset();
        for (int c = 0; c <= 12; c++) begin
            checks++;
            if (got_vec() !== exp_vec()) begin
                errors++; $display("FAIL post_reset c=%0d got=%h exp=%h", c, got_vec(), exp_vec());
            end
            if (c == 3) begin
                checks++;
                if ({Anode_Activate, LED_out, dp_out} !== {4'b1110, 7'b0000001, 1'b1}) begin
                    errors++;
                    $display("FAIL restart_zero got=%b_%b_%b exp=1110_0000001_1", Anode_Activate, LED_out, dp_out);
                end
            end
            step();
        end
    endtask

    task automatic test_random();
        logic [15:0] v;
        apply_reset();
        for (int c = 0; c < 640; c++) begin
            checks++;
            if (got_vec() !== exp_vec()) begin
                errors++; $display("FAIL random c=%0d got=%h exp=%h", c, got_vec(), exp_vec());
            end
            if (c % 50 == 0) bus.blank_lz = 1'($urandom);
            if ($urandom % 6 == 0) begin
                v = 16'($urandom);
                case ($urandom % 4)
                    0: v = v & 16'h00FF;
                    1: v = v & 16'h000F;
                    default: ;
                endcase
                load_val(v, 4'($urandom));
            end
            step();
        end
    endtask

    initial begin
        reset        = 1'b1;
        bus.value_in = '0;
        bus.dp_in    = '0;
        bus.load     = 1'b0;
        bus.blank_lz = 1'b0;
        model_init();
        test_reset();
        test_load_commit();
        test_blanking();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
